// File: rtl/timer_seq_pkg.sv
// Shared types for the programmable interval timer sequencer.
package timer_seq_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/updown_cnt.sv
// WIDTH-bit synchronous counter register with load/inc/dec; holds otherwise.
module updown_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end else if (dec) begin
            count <= count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/timer_seq_ctrl.sv
// Interval timer sequencer: captures limit/mode on start, steps the counter on
// qualified ticks, strobes terminal count, then reloads or parks in DONE.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for start; count held at 0
// ST_RUN  | counting on tick (unless hold); busy=1
// ST_DONE | one-shot finished; count holds terminal value; done=1
module timer_seq_ctrl
    import timer_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             hold,
    input  logic             tick,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir_up,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             tc_pulse
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] limit_q;
    logic             up_q, ar_q;
    logic             capture, cnt_load, cnt_inc, cnt_dec, tc_nxt;
    logic [WIDTH-1:0] cnt_load_val;
    logic             at_term;

    assign at_term = up_q ? (count == limit_q) : (count == '0);

    always_comb begin
        state_nxt    = state;
        capture      = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_inc      = 1'b0;
        cnt_dec      = 1'b0;
        tc_nxt       = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_RUN: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    cnt_load  = 1'b1;
                end else if (start) begin
                    // restart uses the freshly presented inputs, not the latched mode
                    state_nxt    = ST_RUN;
                    capture      = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = dir_up ? '0 : load_val;
                end else if (state == ST_RUN && !hold && tick) begin
                    if (at_term) begin
                        tc_nxt = 1'b1;
                        if (ar_q) begin
                            cnt_load     = 1'b1;
                            cnt_load_val = up_q ? '0 : limit_q;
                        end else begin
                            state_nxt = ST_DONE;
                        end
                    end else begin
                        cnt_inc = up_q;
                        cnt_dec = !up_q;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_load  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            limit_q  <= '0;
            up_q     <= 1'b0;
            ar_q     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tc_pulse <= 1'b0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                limit_q <= load_val;
                up_q    <= dir_up;
                ar_q    <= auto_reload;
            end
            busy     <= (state_nxt == ST_RUN);
            done     <= (state_nxt == ST_DONE);
            tc_pulse <= tc_nxt;
        end
    end

    updown_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .inc      (cnt_inc),
        .dec      (cnt_dec),
        .count    (count)
    );

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Directed bench for timer_seq_ctrl: each step drives inputs, queues the
// expected post-edge outputs, then pops and compares them after the edge.
module tb_timer_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, abort, hold, tick, dir_up, auto_reload;
    logic [3:0] load_val;
    logic [3:0] count;
    logic       busy, done, tc_pulse;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] cnt;
        logic       busy;
        logic       done;
        logic       tc;
        string      tag;
    } exp_t;

    exp_t sb[$];

    timer_seq_ctrl #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .hold        (hold),
        .tick        (tick),
        .load_val    (load_val),
        .dir_up      (dir_up),
        .auto_reload (auto_reload),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .tc_pulse    (tc_pulse)
    );

    always #5 clk = ~clk;

    task automatic check_one();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL sb_empty observed=0 entries expected>=1");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            assert (count === e.cnt) else begin
                failures++;
                $error("FAIL %s.count observed=%0d expected=%0d", e.tag, count, e.cnt);
            end
            checks++;
            assert (busy === e.busy) else begin
                failures++;
                $error("FAIL %s.busy observed=%b expected=%b", e.tag, busy, e.busy);
            end
            checks++;
            assert (done === e.done) else begin
                failures++;
                $error("FAIL %s.done observed=%b expected=%b", e.tag, done, e.done);
            end
            checks++;
            assert (tc_pulse === e.tc) else begin
                failures++;
                $error("FAIL %s.tc_pulse observed=%b expected=%b", e.tag, tc_pulse, e.tc);
            end
        end
    endtask

    task automatic step(input logic s, input logic a, input logic h, input logic t,
                        input logic [3:0] lv, input logic du, input logic ar,
                        input logic [3:0] ec, input logic eb, input logic ed,
                        input logic et, input string tag);
        exp_t e;
        start = s; abort = a; hold = h; tick = t;
        load_val = lv; dir_up = du; auto_reload = ar;
        e.cnt = ec; e.busy = eb; e.done = ed; e.tc = et; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_one();
    endtask

    initial begin
        rst = 1'b1; start = 0; abort = 0; hold = 0; tick = 0;
        load_val = 0; dir_up = 0; auto_reload = 0;
        @(posedge clk); #1;
        step(0,0,0,0, 4'd0,0,0, 4'd0,0,0,0, "reset");
        rst = 1'b0;
        step(0,0,0,1, 4'd0,0,0, 4'd0,0,0,0, "idle_tick");

        // up one-shot, limit 3; mode inputs toggled mid-run must be ignored
        step(1,0,0,1, 4'd3,1,0, 4'd0,1,0,0, "up_start");
        step(0,0,0,1, 4'd9,0,1, 4'd1,1,0,0, "up_c1");
        step(0,0,0,1, 4'd9,0,1, 4'd2,1,0,0, "up_c2");
        step(0,0,0,1, 4'd9,0,1, 4'd3,1,0,0, "up_c3");
        step(0,0,0,1, 4'd9,0,1, 4'd3,0,1,1, "up_tc");
        step(0,0,0,1, 4'd9,0,1, 4'd3,0,1,0, "up_done1");
        step(0,0,0,1, 4'd9,0,1, 4'd3,0,1,0, "up_done2");

        // down periodic, limit 2, restarted from DONE
        step(1,0,0,1, 4'd2,0,1, 4'd2,1,0,0, "dn_start");
        step(0,0,0,1, 4'd0,1,0, 4'd1,1,0,0, "dn_c1");
        step(0,0,0,0, 4'd0,1,0, 4'd1,1,0,0, "dn_notick");
        step(0,0,0,1, 4'd0,1,0, 4'd0,1,0,0, "dn_c0");
        step(0,0,0,1, 4'd0,1,0, 4'd2,1,0,1, "dn_tc1");
        step(0,0,0,1, 4'd0,1,0, 4'd1,1,0,0, "dn_c1b");
        step(0,0,0,1, 4'd0,1,0, 4'd0,1,0,0, "dn_c0b");
        step(0,0,0,1, 4'd0,1,0, 4'd2,1,0,1, "dn_tc2");

        // hold at count 5
        step(1,0,0,1, 4'd9,1,0, 4'd0,1,0,0, "hd_start");
        for (int i = 1; i <= 5; i++)
            step(0,0,0,1, 4'd0,0,0, 4'(i),1,0,0, "hd_cnt");
        for (int i = 0; i < 4; i++)
            step(0,0,1,1, 4'd0,0,0, 4'd5,1,0,0, "hd_hold");
        step(0,0,0,1, 4'd0,0,0, 4'd6,1,0,0, "hd_resume");

        // abort beats start; then start-in-RUN restarts and ignores tick
        step(1,1,0,1, 4'd4,1,0, 4'd0,0,0,0, "ab_start");
        step(1,0,0,1, 4'd5,1,0, 4'd0,1,0,0, "re_start");
        step(0,0,0,1, 4'd0,0,0, 4'd1,1,0,0, "re_c1");
        step(1,0,0,1, 4'd7,0,0, 4'd7,1,0,0, "rs_down7");
        step(0,0,0,1, 4'd0,1,1, 4'd6,1,0,0, "rs_c6");
        step(0,1,0,1, 4'd0,0,0, 4'd0,0,0,0, "ab_tick");

        // limit 0, up, auto-reload: tc on every tick
        step(1,0,0,1, 4'd0,1,1, 4'd0,1,0,0, "z_start");
        step(0,0,0,1, 4'd0,0,0, 4'd0,1,0,1, "z_tc1");
        step(0,0,0,1, 4'd0,0,0, 4'd0,1,0,1, "z_tc2");
        step(0,0,0,0, 4'd0,0,0, 4'd0,1,0,0, "z_idle");
        step(0,0,0,1, 4'd0,0,0, 4'd0,1,0,1, "z_tc3");

        // reset mid-run with nonzero count
        step(1,0,0,1, 4'd8,0,0, 4'd8,1,0,0, "mr_start");
        step(0,0,0,1, 4'd0,0,0, 4'd7,1,0,0, "mr_c7");
        rst = 1'b1;
        step(0,0,0,1, 4'd0,0,0, 4'd0,0,0,0, "mr_reset");
        rst = 1'b0;
        step(0,0,0,1, 4'd0,0,0, 4'd0,0,0,0, "mr_after");

        // abort out of DONE
        step(1,0,0,1, 4'd1,1,0, 4'd0,1,0,0, "ad_start");
        step(0,0,0,1, 4'd0,0,0, 4'd1,1,0,0, "ad_c1");
        step(0,0,0,1, 4'd0,0,0, 4'd1,0,1,1, "ad_tc");
        step(0,1,0,0, 4'd0,0,0, 4'd0,0,0,0, "ad_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
